// File: rtl/uart_word_assembler.sv
// uart_word_assembler: pairs received UART bytes into 16-bit display words.
// The first good byte is the high byte and the next good byte is the low byte.
// Any byte with a parity or framing error forces ERR_WORD onto the display.
// A stalled high byte is dropped after TIMEOUT_CYCLES idle cycles.
module uart_word_assembler #(
  parameter logic [15:0] BLANK_WORD     = 16'hCCCC,
  parameter logic [15:0] ERR_WORD       = 16'hEEEE,
  parameter int          TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_perror,
  input  logic        rx_ferror,
  output logic [15:0] word,
  output logic        word_valid,
  output logic        err,
  output logic [7:0]  frame_cnt
);

  // Last counter value before the pending high byte is abandoned.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HI  = 2'd0,
    S_LO  = 2'd1,
    S_ERR = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] word_q, word_d;
  logic        wv_q, wv_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic good_byte, bad_byte, tmo_hit;

  // The error flags only mean something while the strobe is high.
  assign good_byte = rx_valid & ~rx_perror & ~rx_ferror;
  assign bad_byte  = rx_valid & (rx_perror | rx_ferror);
  assign tmo_hit   = (tmo_q == TMO_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_HI;
    else        state_q <= state_d;
  end

  // Next-state logic. A byte always beats a timeout that expires in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HI, S_ERR: begin
        if (bad_byte)       state_d = S_ERR;
        else if (good_byte) state_d = S_LO;
      end
      S_LO: begin
        if (bad_byte)       state_d = S_ERR;
        else if (good_byte) state_d = S_HI;
        else if (tmo_hit)   state_d = S_HI;
      end
      default: state_d = S_HI;
    endcase
  end

  // Output and datapath next values. By default the display holds its value and no pulse is made.
  always_comb begin
    hi_d   = hi_q;
    tmo_d  = 16'd0;
    word_d = word_q;
    wv_d   = 1'b0;
    err_d  = err_q;
    cnt_d  = cnt_q;
    if (bad_byte) begin
      // Show the error word and throw away any half-built word.
      word_d = ERR_WORD;
      err_d  = 1'b1;
      wv_d   = 1'b1;
      hi_d   = 8'd0;
    end else if (good_byte) begin
      if (state_q == S_LO) begin
        word_d = {hi_q, rx_data};
        wv_d   = 1'b1;
        err_d  = 1'b0;
        cnt_d  = cnt_q + 8'd1;
      end else begin
        hi_d = rx_data;
      end
    end else if (state_q == S_LO) begin
      if (tmo_hit) hi_d = 8'd0;
      else         tmo_d = tmo_q + 16'd1;
    end
  end

  // Datapath and output registers. All outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q   <= 8'd0;
      tmo_q  <= 16'd0;
      word_q <= BLANK_WORD;
      wv_q   <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= 8'd0;
    end else begin
      hi_q   <= hi_d;
      tmo_q  <= tmo_d;
      word_q <= word_d;
      wv_q   <= wv_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word       = word_q;
  assign word_valid = wv_q;
  assign err        = err_q;
  assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_uart_word_assembler.sv
// Bench for uart_word_assembler. Each stimulus task pushes the word update it should
// cause onto a scoreboard queue, and a monitor pops an entry for every word_valid pulse.
module tb_uart_word_assembler;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_perror, rx_ferror;
  logic [15:0] word;
  logic        word_valid, err;
  logic [7:0]  frame_cnt;

  typedef struct {
    logic [15:0] word;
    logic        err;
    logic [7:0]  cnt;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [7:0]  cnt_e = 8'd0;

  uart_word_assembler #(
    .BLANK_WORD    (16'hCCCC),
    .ERR_WORD      (16'hEEEE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_perror (rx_perror),
    .rx_ferror (rx_ferror),
    .word      (word),
    .word_valid(word_valid),
    .err       (err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Every pulse must match the oldest pending expectation, in the promised cycle.
  always @(negedge clk) begin
    if (word_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_word_valid", 32'(word), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("word", 32'(word), 32'(e.word));
        chk("err", 32'(err), 32'(e.err));
        chk("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
        chk("latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Drive one cycle of input. Inputs change 1 time unit after the edge.
  task automatic drv(input logic v, input logic [7:0] d, input logic pe, input logic fe);
    rx_valid = v; rx_data = d; rx_perror = pe; rx_ferror = fe;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_perror = 1'b0; rx_ferror = 1'b0; rx_data = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) drv(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [15:0] w, input logic e);
    exp_t x;
    x.word = w; x.err = e; x.cnt = cnt_e; x.cyc = cyc + 1;
    sb.push_back(x);
  endtask

  // A good byte that completes a word.
  task automatic lo_good(input logic [7:0] hi, input logic [7:0] lo);
    cnt_e = cnt_e + 8'd1;
    push({hi, lo}, 1'b0);
    drv(1'b1, lo, 1'b0, 1'b0);
  endtask

  task automatic bad(input logic [7:0] d, input logic pe, input logic fe);
    push(16'hEEEE, 1'b1);
    drv(1'b1, d, pe, fe);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    rx_valid = 1'b1; rx_data = 8'h5A; rx_perror = 1'b0; rx_ferror = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    reset = 1'b1;
    rx_valid = 1'b0; rx_data = 8'h00;
    cnt_e = 8'd0;
    chk("rst_word", 32'(word), 32'hCCCC);
    chk("rst_word_valid", 32'(word_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
  endtask

  initial begin
    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_perror = 1'b0; rx_ferror = 1'b0;
    @(posedge clk); #1;
    // Reset is held with a live strobe on the bus, which reset must override.
    do_reset(3);

    // Basic word, low byte five cycles after high byte.
    drv(1'b1, 8'h12, 1'b0, 1'b0);
    idle(4);
    lo_good(8'h12, 8'h34);
    chk("single_pulse", 32'(word_valid), 32'd1);
    idle(1);
    chk("pulse_ends", 32'(word_valid), 32'd0);

    // Parity error on the low byte, then a framing error in the error state.
    drv(1'b1, 8'hAB, 1'b0, 1'b0);
    bad(8'hCD, 1'b1, 1'b0);
    idle(2);
    chk("err_level", 32'(err), 32'd1);
    bad(8'h99, 1'b0, 1'b1);
    drv(1'b1, 8'h56, 1'b0, 1'b0);
    lo_good(8'h56, 8'h78);
    idle(1);
    chk("err_cleared", 32'(err), 32'd0);

    // Error flags and data with no strobe are ignored, in both the high-byte and low-byte states.
    drv(1'b0, 8'hFF, 1'b1, 1'b1);
    drv(1'b1, 8'h11, 1'b0, 1'b0);
    drv(1'b0, 8'hFF, 1'b1, 1'b1);
    lo_good(8'h11, 8'h22);

    // A bad byte while waiting for a high byte.
    bad(8'h00, 1'b0, 1'b1);

    // Timeout: eight idle cycles drop 8'h11, so 8'h22 becomes the new high byte.
    drv(1'b1, 8'h11, 1'b0, 1'b0);
    idle(TMO);
    drv(1'b1, 8'h22, 1'b0, 1'b0);
    lo_good(8'h22, 8'h33);

    // The low byte arrives in the exact expiry cycle, and the byte wins.
    drv(1'b1, 8'h44, 1'b0, 1'b0);
    idle(TMO - 1);
    lo_good(8'h44, 8'h55);

    // A bad byte in the expiry cycle also wins.
    drv(1'b1, 8'h66, 1'b0, 1'b0);
    idle(TMO - 1);
    bad(8'h77, 1'b1, 1'b0);

    // A one-cycle reset between the high and low bytes discards the pending byte.
    drv(1'b1, 8'h9A, 1'b0, 1'b0);
    do_reset(1);
    drv(1'b1, 8'hBC, 1'b0, 1'b0);
    lo_good(8'hBC, 8'hDE);
    idle(1);
    chk("post_rst_cnt", 32'(frame_cnt), 32'd1);

    // frame_cnt wraps after 256 good words from reset.
    do_reset(1);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] h, l;
      h = 8'(i); l = 8'(i ^ 8'hA5);
      drv(1'b1, h, 1'b0, 1'b0);
      lo_good(h, l);
      if (i == 254) chk("cnt_255th", 32'(frame_cnt), 32'h00FF);
    end
    chk("cnt_wrap", 32'(frame_cnt), 32'h0000);

    idle(3);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_word_assembler.md
UART_WORD_ASSEMBLER -- requirements
Module: uart_word_assembler

Interface
REQ-001 Parameter: BLANK_WORD, 16'hCCCC, display word held after reset until the first complete word.
REQ-002 Parameter: ERR_WORD, 16'hEEEE, display word shown after any receive error.
REQ-003 Parameter: TIMEOUT_CYCLES, 1000, maximum clk cycles allowed between the high byte and the low byte of one word; legal range 2..65535.
REQ-004 The block SHALL use exactly one clock, clk, and one reset, reset; reset is synchronous and active-low (asserted when 0, sampled only on the rising edge of clk).
REQ-005 Port list SHALL be:
  clk        input   1   rising-edge system clock
  reset      input   1   synchronous active-low reset
  rx_data    input   8   received byte, valid only when rx_valid=1
  rx_valid   input   1   one-cycle strobe, new byte present
  rx_perror  input   1   parity error flag, qualified by rx_valid
  rx_ferror  input   1   framing error flag, qualified by rx_valid
  word       output  16  display word, nibble [15:12] leftmost digit
  word_valid output  1   one-cycle pulse, word register written this cycle
  err        output  1   level, last word update was an error
  frame_cnt  output  8   count of good words assembled

Function
REQ-006 All outputs SHALL be registered; no output depends combinationally on any input.
REQ-007 The FSM SHALL have three states: S_HI (await high byte), S_LO (await low byte), S_ERR (error shown, await high byte).
REQ-008 A byte is "good" when rx_valid=1 and rx_perror=0 and rx_ferror=0; "bad" when rx_valid=1 and either error flag=1; rx_data and both error flags SHALL be ignored when rx_valid=0.
REQ-009 S_HI or S_ERR, good byte: latch rx_data as high byte, clear the timeout counter, go to S_LO; word, err, frame_cnt unchanged.
REQ-010 S_LO, good byte: at the same edge word <= {high byte, rx_data}, word_valid=1 for one cycle, err <= 0, frame_cnt increments, state -> S_HI.
REQ-011 Latency: word/word_valid SHALL be visible in the cycle immediately following the cycle in which the completing rx_valid was high (1-cycle latency).
REQ-012 Any state, bad byte: word <= ERR_WORD, err <= 1, word_valid=1 for one cycle, stored high byte discarded, state -> S_ERR; frame_cnt unchanged.
REQ-013 S_ERR, further bad bytes: word stays ERR_WORD, word_valid pulses again for each bad byte, err stays 1.
REQ-014 S_LO timeout counter SHALL increment each cycle with rx_valid=0; on reaching TIMEOUT_CYCLES-1 the high byte is discarded and state -> S_HI; word, err, frame_cnt unchanged, no word_valid pulse.
REQ-015 Timeout counter width SHALL be 16 bits; counter held at 0 outside S_LO.
REQ-016 Simultaneous rx_valid and timeout expiry in S_LO: the byte SHALL take priority (good completes word, bad enters S_ERR); timeout ignored.
REQ-017 frame_cnt SHALL wrap 8'hFF -> 8'h00 without saturation or flag.
REQ-018 word_valid SHALL be 0 in every cycle not listed in REQ-010/012/013.

Reset
REQ-019 With reset=0 at a rising edge: word=BLANK_WORD, word_valid=0, err=0, frame_cnt=0, state=S_HI, timeout counter=0, stored high byte=0.
REQ-020 Reset SHALL override all inputs in the same cycle, including an rx_valid strobe; a reset in S_LO discards the pending high byte.
REQ-021 First good byte after reset release SHALL be treated as a high byte.

Verification
REQ-022 Reset, then bytes 8'h12, 8'h34 (good, 5 cycles apart) -> word=16'h1234 one cycle after second strobe, word_valid single pulse, err=0, frame_cnt=1.
REQ-023 Byte 8'hAB good, then 8'hCD with rx_perror=1 -> word=16'hEEEE, err=1, frame_cnt unchanged; then good 8'h56, 8'h78 -> word=16'h5678, err=0.
REQ-024 TIMEOUT_CYCLES=8: byte 8'h11, no strobe for 8 cycles, then 8'h22, 8'h33 -> word=16'h2233, no update in between, 8'h11 never appears.
REQ-025 TIMEOUT_CYCLES=8: low byte strobe in exactly the expiry cycle -> word completes with the held high byte (byte wins).
REQ-026 256 good words from reset -> frame_cnt=8'h00 after the last, 8'hFF after the 255th.
REQ-027 reset=0 for one cycle between high and low byte -> word=BLANK_WORD, next good pair assembles normally with frame_cnt=1.
